// File: rtl/pipe_flow_ctrl_if.sv
// pipe_flow_ctrl_if: hazard/flow-control signals between pipeline stages and pipe_flow_ctrl.
interface pipe_flow_ctrl_if;
  logic [4:0] id_rs1_raddr_i;
  logic       id_rs1_re_i;
  logic [4:0] id_rs2_raddr_i;
  logic       id_rs2_re_i;
  logic [4:0] idex_reg_waddr_i;
  logic       idex_mtype_i;
  logic       idex_mem_rw_i;
  logic       ex_jump_flag_i;
  logic       mem_req_i;
  logic       mem_ack_i;
  logic       fc_stall_pc_o;
  logic       fc_stall_ifid_o;
  logic       fc_flush_ifid_o;
  logic       fc_stall_idex_o;
  logic       fc_flush_idex_o;
  logic       fc_stall_exmem_o;
  logic       fc_mem_timeout_o;
  modport master (
    output id_rs1_raddr_i, id_rs1_re_i, id_rs2_raddr_i, id_rs2_re_i,
           idex_reg_waddr_i, idex_mtype_i, idex_mem_rw_i, ex_jump_flag_i, mem_req_i, mem_ack_i,
    input  fc_stall_pc_o, fc_stall_ifid_o, fc_flush_ifid_o, fc_stall_idex_o, fc_flush_idex_o,
           fc_stall_exmem_o, fc_mem_timeout_o
  );
  modport slave (
    input  id_rs1_raddr_i, id_rs1_re_i, id_rs2_raddr_i, id_rs2_re_i,
           idex_reg_waddr_i, idex_mtype_i, idex_mem_rw_i, ex_jump_flag_i, mem_req_i, mem_ack_i,
    output fc_stall_pc_o, fc_stall_ifid_o, fc_flush_ifid_o, fc_stall_idex_o, fc_flush_idex_o,
           fc_stall_exmem_o, fc_mem_timeout_o
  );
endinterface

// File: rtl/pipe_flow_ctrl.sv
// pipe_flow_ctrl: pipeline stall/flush control for memory waits, load-use hazards and redirects.
// Define FC_TIMEOUT_EN to bound MEM_WAIT with an 8-bit timeout counter.
module pipe_flow_ctrl (
  input logic clk,
  input logic rst_n,
  pipe_flow_ctrl_if.slave fc
);
  typedef enum logic [1:0] {IDLE, MEM_WAIT, REDIRECT} state_t;
  state_t state, state_nx;
  logic redir_pend, redir_pend_nx;
  logic ack, timeout_hit, mem_busy, jump, redirect, load_use;
`ifdef FC_TIMEOUT_EN
  logic [7:0] cnt;
  logic timeout_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt <= (state == MEM_WAIT && !ack) ? cnt + 8'd1 : '0;
      timeout_q <= timeout_hit;
    end
  // Fires on the cycle the count would reach 255, so the stall spans exactly 255 cycles
  assign timeout_hit = state == MEM_WAIT && !fc.mem_ack_i && cnt == 8'd254;
  assign fc.fc_mem_timeout_o = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign fc.fc_mem_timeout_o = 1'b0;
`endif
  assign ack = fc.mem_ack_i || timeout_hit;
  // Outputs are forced quiet while reset is held, whatever the inputs do
  assign mem_busy = rst_n && (state == MEM_WAIT ? !ack : fc.mem_req_i && !fc.mem_ack_i);
  assign jump = rst_n && !mem_busy && fc.ex_jump_flag_i;
  assign redirect = !mem_busy && !jump && state == REDIRECT;
  assign load_use = rst_n && !mem_busy && !jump && state != REDIRECT &&
                    fc.idex_mtype_i && !fc.idex_mem_rw_i && |fc.idex_reg_waddr_i &&
                    ((fc.id_rs1_re_i && fc.id_rs1_raddr_i == fc.idex_reg_waddr_i) ||
                     (fc.id_rs2_re_i && fc.id_rs2_raddr_i == fc.idex_reg_waddr_i));
  assign fc.fc_stall_pc_o = mem_busy || load_use;
  assign fc.fc_stall_ifid_o = mem_busy || load_use;
  assign fc.fc_flush_ifid_o = jump || redirect;
  assign fc.fc_stall_idex_o = mem_busy;
  assign fc.fc_flush_idex_o = jump || load_use;
  assign fc.fc_stall_exmem_o = mem_busy;
  always_comb begin
    state_nx = state;
    redir_pend_nx = redir_pend;
    if (state == MEM_WAIT) begin
      state_nx = !ack ? MEM_WAIT : (redir_pend || fc.ex_jump_flag_i) ? REDIRECT : IDLE;
      redir_pend_nx = !ack && (redir_pend || fc.ex_jump_flag_i);
    end else begin
      state_nx = mem_busy ? MEM_WAIT : fc.ex_jump_flag_i ? REDIRECT : IDLE;
      redir_pend_nx = mem_busy && (state == REDIRECT || fc.ex_jump_flag_i);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      redir_pend <= 1'b0;
    end else begin
      state <= state_nx;
      redir_pend <= redir_pend_nx;
    end
endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// tb_pipe_flow_ctrl: directed scenarios plus randomized traffic against a behavioural flow-control model.
module tb_pipe_flow_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_run = 0;
  int n_fail = 0;
  localparam logic [6:0] STALL4 = 7'b1101010;
  localparam logic [6:0] LU     = 7'b1100100;
  localparam logic [6:0] JMP    = 7'b0010100;
  localparam logic [6:0] RDR    = 7'b0010000;
  localparam logic [6:0] NONE   = 7'b0000000;
  localparam logic [6:0] TOUT   = 7'b0000001;
  pipe_flow_ctrl_if bus();
  pipe_flow_ctrl dut (.clk(clk), .rst_n(rst_n), .fc(bus.slave));
  logic [6:0] obs;
  assign obs = {bus.fc_stall_pc_o, bus.fc_stall_ifid_o, bus.fc_flush_ifid_o, bus.fc_stall_idex_o,
                bus.fc_flush_idex_o, bus.fc_stall_exmem_o, bus.fc_mem_timeout_o};
  always #5 clk = ~clk;
  task automatic set_in(input logic [4:0] rs1, input logic re1, input logic [4:0] rs2, input logic re2,
                        input logic [4:0] wa, input logic mt, input logic rw,
                        input logic j, input logic rq, input logic ak);
    @(posedge clk);
    #1;
    bus.id_rs1_raddr_i = rs1;
    bus.id_rs1_re_i = re1;
    bus.id_rs2_raddr_i = rs2;
    bus.id_rs2_re_i = re2;
    bus.idex_reg_waddr_i = wa;
    bus.idex_mtype_i = mt;
    bus.idex_mem_rw_i = rw;
    bus.ex_jump_flag_i = j;
    bus.mem_req_i = rq;
    bus.mem_ack_i = ak;
    @(negedge clk);
  endtask
  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic mem(input logic j, input logic rq, input logic ak);
    set_in(0, 0, 0, 0, 0, 0, 0, j, rq, ak);
  endtask
  task automatic test_reset();
    bus.id_rs1_raddr_i = 0; bus.id_rs1_re_i = 0; bus.id_rs2_raddr_i = 0; bus.id_rs2_re_i = 0;
    bus.idex_reg_waddr_i = 0; bus.idex_mtype_i = 0; bus.idex_mem_rw_i = 0;
    bus.ex_jump_flag_i = 0; bus.mem_req_i = 0; bus.mem_ack_i = 0;
    #12;
    n_run++;
    if (obs !== NONE) begin n_fail++; $display("FAIL reset_held: got %b want %b", obs, NONE); end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    n_run++;
    if (obs !== NONE) begin n_fail++; $display("FAIL reset_release: got %b want %b", obs, NONE); end
  endtask
  task automatic test_load_use();
    logic [6:0] want [6];
    logic [6:0] got [6];
    set_in(5, 1, 0, 0, 5, 1, 0, 0, 0, 0); got[0] = obs; want[0] = LU;
    idle();                                got[1] = obs; want[1] = NONE;
    set_in(0, 1, 0, 0, 0, 1, 0, 0, 0, 0); got[2] = obs; want[2] = NONE;
    set_in(1, 1, 7, 1, 7, 1, 0, 0, 0, 0); got[3] = obs; want[3] = LU;
    set_in(7, 1, 0, 0, 7, 1, 1, 0, 0, 0); got[4] = obs; want[4] = NONE;
    set_in(7, 0, 7, 0, 7, 1, 0, 0, 0, 0); got[5] = obs; want[5] = NONE;
    for (int i = 0; i < 6; i++) begin
      n_run++;
      if (got[i] !== want[i]) begin n_fail++; $display("FAIL load_use[%0d]: got %b want %b", i, got[i], want[i]); end
    end
  endtask
  task automatic test_jump();
    logic [6:0] want [4] = '{JMP, RDR, NONE, NONE};
    logic [6:0] got [4];
    mem(1, 0, 0); got[0] = obs;
    idle();       got[1] = obs;
    idle();       got[2] = obs;
    set_in(3, 1, 0, 0, 3, 1, 0, 0, 0, 0); got[3] = obs;
    want[3] = LU;
    for (int i = 0; i < 4; i++) begin
      n_run++;
      if (got[i] !== want[i]) begin n_fail++; $display("FAIL jump[%0d]: got %b want %b", i, got[i], want[i]); end
    end
  endtask
  task automatic test_mem_wait();
    logic [6:0] want [7] = '{STALL4, STALL4, STALL4, NONE, NONE, NONE, NONE};
    logic [6:0] got [7];
    mem(0, 1, 0); got[0] = obs;
    mem(0, 1, 0); got[1] = obs;
    mem(0, 1, 0); got[2] = obs;
    mem(0, 1, 1); got[3] = obs;
    idle();       got[4] = obs;
    mem(0, 1, 1); got[5] = obs;
    idle();       got[6] = obs;
    for (int i = 0; i < 7; i++) begin
      n_run++;
      if (got[i] !== want[i]) begin n_fail++; $display("FAIL mem_wait[%0d]: got %b want %b", i, got[i], want[i]); end
    end
  endtask
  task automatic test_jump_in_wait();
    logic [6:0] want [5] = '{STALL4, STALL4, JMP, RDR, NONE};
    logic [6:0] got [5];
    mem(1, 1, 0); got[0] = obs;
    mem(1, 1, 0); got[1] = obs;
    mem(1, 1, 1); got[2] = obs;
    idle();       got[3] = obs;
    idle();       got[4] = obs;
    for (int i = 0; i < 5; i++) begin
      n_run++;
      if (got[i] !== want[i]) begin n_fail++; $display("FAIL jump_in_wait[%0d]: got %b want %b", i, got[i], want[i]); end
    end
  endtask
  task automatic test_redirect_mem();
    logic [6:0] want [6] = '{JMP, STALL4, STALL4, NONE, RDR, NONE};
    logic [6:0] got [6];
    mem(1, 0, 0); got[0] = obs;
    mem(0, 1, 0); got[1] = obs;
    mem(0, 1, 0); got[2] = obs;
    mem(0, 1, 1); got[3] = obs;
    idle();       got[4] = obs;
    idle();       got[5] = obs;
    for (int i = 0; i < 6; i++) begin
      n_run++;
      if (got[i] !== want[i]) begin n_fail++; $display("FAIL redirect_mem[%0d]: got %b want %b", i, got[i], want[i]); end
    end
  endtask
  task automatic test_timeout();
    int n = 0;
`ifdef FC_TIMEOUT_EN
    for (int i = 0; i < 400; i++) begin
      mem(0, 1, 0);
      if (!obs[1]) break;
      n++;
    end
    n_run++;
    if (n != 255) begin n_fail++; $display("FAIL timeout_len: got %0d want 255", n); end
    n_run++;
    if (obs !== NONE) begin n_fail++; $display("FAIL timeout_release: got %b want %b", obs, NONE); end
    idle();
    n_run++;
    if (obs !== TOUT) begin n_fail++; $display("FAIL timeout_pulse: got %b want %b", obs, TOUT); end
    idle();
    n_run++;
    if (obs !== NONE) begin n_fail++; $display("FAIL timeout_after: got %b want %b", obs, NONE); end
`else
    for (int i = 0; i < 300; i++) begin
      mem(0, 1, 0);
      n += int'(obs === STALL4);
    end
    n_run++;
    if (n != 300) begin n_fail++; $display("FAIL no_timeout_len: got %0d want 300", n); end
    mem(0, 1, 1);
    n_run++;
    if (obs !== NONE) begin n_fail++; $display("FAIL no_timeout_ack: got %b want %b", obs, NONE); end
    idle();
    n_run++;
    if (obs !== NONE) begin n_fail++; $display("FAIL no_timeout_after: got %b want %b", obs, NONE); end
`endif
  endtask
  task automatic test_reset_mid_wait();
    mem(1, 1, 0);
    mem(1, 1, 0);
    rst_n = 1'b0;
    #1;
    n_run++;
    if (obs !== NONE) begin n_fail++; $display("FAIL reset_mid_wait: got %b want %b", obs, NONE); end
    @(posedge clk);
    @(negedge clk);
    bus.ex_jump_flag_i = 0; bus.mem_req_i = 0;
    rst_n = 1'b1;
    idle();
    n_run++;
    if (obs !== NONE) begin n_fail++; $display("FAIL reset_discard0: got %b want %b", obs, NONE); end
    idle();
    n_run++;
    if (obs !== NONE) begin n_fail++; $display("FAIL reset_discard1: got %b want %b", obs, NONE); end
  endtask
  task automatic test_random();
    bit waiting = 0, redir_due = 0, deferred = 0, pulse = 0;
    int wcnt = 0;
    for (int c = 0; c < 600; c++) begin
      logic [4:0] rs1, rs2, wa;
      logic re1, re2, mt, rw, j, rq, ak, timed, done, busy, lu;
      logic [6:0] exp;
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3)); wa = 5'($urandom_range(0, 3));
      re1 = 1'($urandom); re2 = 1'($urandom); mt = 1'($urandom); rw = 1'($urandom);
      j = $urandom_range(0, 4) == 0;
      rq = waiting ? 1'b1 : $urandom_range(0, 3) == 0;
      ak = $urandom_range(0, 2) == 0;
      set_in(rs1, re1, rs2, re2, wa, mt, rw, j, rq, ak);
      timed = 0;
`ifdef FC_TIMEOUT_EN
      timed = waiting && !ak && wcnt == 254;
`endif
      done = ak || timed;
      busy = waiting ? !done : (rq && !ak);
      lu = mt && !rw && wa != 0 && ((re1 && rs1 == wa) || (re2 && rs2 == wa));
      exp = busy ? STALL4 : j ? JMP : redir_due ? RDR : lu ? LU : NONE;
      exp[0] = pulse;
      n_run++;
      if (obs !== exp) begin n_fail++; $display("FAIL random[%0d]: got %b want %b", c, obs, exp); end
      pulse = timed;
      if (waiting) begin
        if (done) begin
          waiting = 0; redir_due = deferred || j; deferred = 0; wcnt = 0;
        end else begin
          deferred = deferred || j; wcnt++;
        end
      end else if (busy) begin
        waiting = 1; deferred = redir_due || j; redir_due = 0; wcnt = 0;
      end else
        redir_due = j;
    end
  endtask
  initial begin
    test_reset();
    test_load_use();
    test_jump();
    test_mem_wait();
    test_jump_in_wait();
    test_redirect_mem();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_flow_ctrl.md
PIPE_FLOW_CTRL -- requirements
Module: pipe_flow_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have inputs: id_rs1_raddr_i 5 / id_rs1_re_i 1 / id_rs2_raddr_i 5 / id_rs2_re_i 1  ID source regs and read enables.
REQ-003 SHALL have inputs: idex_reg_waddr_i 5, idex_mtype_i 1, idex_mem_rw_i 1 (0=load)  instruction in EX.
REQ-004 SHALL have inputs: ex_jump_flag_i 1  taken branch/jump resolved in EX; mem_req_i 1  MEM-stage data request; mem_ack_i 1  data memory completion.
REQ-005 SHALL have outputs (1 bit each): fc_stall_pc_o, fc_stall_ifid_o, fc_flush_ifid_o, fc_stall_idex_o, fc_flush_idex_o, fc_stall_exmem_o, fc_mem_timeout_o.

Function
REQ-006 SHALL hold a registered FSM with states IDLE, MEM_WAIT, REDIRECT, plus a registered redir_pend bit.
REQ-007 mem_busy = (IDLE or REDIRECT) & mem_req_i & ~mem_ack_i, or MEM_WAIT & ~mem_ack_i; combinational.
REQ-008 mem_busy=1: all four stall outputs = 1, both flush outputs = 0; highest priority.
REQ-009 mem_ack_i in same cycle as mem_req_i from IDLE: zero-wait, no stall, state stays IDLE.
REQ-010 MEM_WAIT -> IDLE on mem_ack_i if redir_pend=0, else -> REDIRECT and clear redir_pend; stalls deassert in the ack cycle.
REQ-011 Load-use (mem_busy=0): idex_mtype_i & ~idex_mem_rw_i & idex_reg_waddr_i!=0 & ((id_rs1_re_i & rs1==waddr) | (id_rs2_re_i & rs2==waddr)) -> fc_stall_pc_o=1, fc_stall_ifid_o=1, fc_flush_idex_o=1, single cycle.
REQ-012 Jump (mem_busy=0, ex_jump_flag_i=1): fc_flush_ifid_o=1, fc_flush_idex_o=1, no stalls; load-use suppressed; state -> REDIRECT.
REQ-013 REDIRECT (mem_busy=0): fc_flush_ifid_o=1 for exactly one cycle, then -> IDLE (or REDIRECT again if ex_jump_flag_i=1).
REQ-014 ex_jump_flag_i=1 while mem_busy=1: jump deferred, redir_pend set; EX held so jump re-evaluates after stall.
REQ-015 Mem request in REDIRECT with no ack: -> MEM_WAIT, redir_pend=1; REDIRECT flush delivered after ack.
REQ-016 All outputs default 0 when no condition applies; fc_stall_exmem_o asserts only from mem_busy.

Reset
REQ-017 rst_n low: state=IDLE, redir_pend=0, timeout counter=0, fc_mem_timeout_o=0; combinational outputs then evaluate to 0 with idle inputs.
REQ-018 Reset mid-MEM_WAIT aborts the wait; pending redirect discarded.

Configuration
REQ-019 Macro FC_TIMEOUT_EN defined: 8-bit counter increments each MEM_WAIT cycle without ack, clears on leaving MEM_WAIT.
REQ-020 With FC_TIMEOUT_EN: counter reaching 255 forces MEM_WAIT exit (as if acked), fc_mem_timeout_o registered 1-cycle pulse next cycle, counter cleared.
REQ-021 Without FC_TIMEOUT_EN: no counter, fc_mem_timeout_o tied 0, MEM_WAIT waits indefinitely.

Verification
REQ-022 Load x5 in EX (mtype=1,rw=0,waddr=5), ID rs1=5 re=1 -> stall_pc=stall_ifid=flush_idex=1 one cycle; waddr=0 -> no stall.
REQ-023 ex_jump_flag_i pulse 1 cycle -> flush_ifid=flush_idex=1 cycle N, flush_ifid=1 cycle N+1, then all 0.
REQ-024 mem_req_i=1, mem_ack_i at cycle +3 -> four stalls high cycles 0-2, low cycle 3, IDLE after; req+ack same cycle -> no stall.
REQ-025 Jump during MEM_WAIT -> no flush while stalled; after ack, flush_ifid + flush_idex, then REDIRECT flush_ifid.
REQ-026 FC_TIMEOUT_EN, req with no ack -> stalls for 255 cycles, release, fc_mem_timeout_o 1-cycle pulse; reset asserted mid-wait -> all outputs 0 immediately.
